// File: rtl/muldiv_ctrl_pkg.sv
// Shared op encodings, FSM state codes and default parameters for the mul/div sequencer.
// Imported by the sequencer, its interface and the main control unit.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MFHI = 2'b10,
        OP_MFLO = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WB    = 2'b11
    } state_t;

    // Nominal unit latency is 32-33 cycles; the watchdog leaves some margin above that.
    localparam int TIMEOUT_DEF = 40;
    localparam int CNT_W_DEF   = 6;

    function automatic logic is_unit_op(op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle of control-unit request signals and multiplier/divider launch/result signals.
// The sequencer sits on the slave modport; the control unit and the two units sit on master.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    // Handshake: an op transfers on a clock edge where req_valid && req_ready. The requester
    // holds req_valid and req_op stable until that edge; req_ready depends only on FSM state.
    logic        req_valid;
    op_t         req_op;
    logic        req_ready;
    logic        stall;

    logic        mult_start;
    logic        mult_done;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;

    logic        div_start;
    logic        div_done;
    logic        div_zero;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mf_data;
    logic        mf_valid;
    logic        div_zero_exc;
    logic        timeout_err;

    modport master (
        output req_valid, req_op,
        output mult_done, mult_hi, mult_lo,
        output div_done, div_zero, div_hi, div_lo,
        input  req_ready, stall,
        input  mult_start, div_start,
        input  hi_out, lo_out, mf_data, mf_valid, div_zero_exc, timeout_err
    );

    modport slave (
        input  req_valid, req_op,
        input  mult_done, mult_hi, mult_lo,
        input  div_done, div_zero, div_hi, div_lo,
        output req_ready, stall,
        output mult_start, div_start,
        output hi_out, lo_out, mf_data, mf_valid, div_zero_exc, timeout_err
    );

endinterface

// File: rtl/muldiv_watchdog.sv
// WAIT-phase watchdog: counts enabled cycles since the last clear and flags when TIMEOUT is reached.
module muldiv_watchdog #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at LIMIT so a caller that keeps enable high cannot wrap the flag away.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between the control unit and the shared multiplier/divider pair.
// Owns architectural HI/LO, stalls requests while a unit is busy, flags div-by-zero and timeout.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    muldiv_ctrl_if.slave bus,
    output state_t       dbg_state
);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] stg_hi_q, stg_hi_d;
    logic [31:0] stg_lo_q, stg_lo_d;
    logic        stg_zero_q, stg_zero_d;
    logic [31:0] mf_data_q, mf_data_d;
    logic        mf_valid_q, mf_valid_d;
    logic        mult_start_q, mult_start_d;
    logic        div_start_q, div_start_d;
    logic        dz_exc_q, dz_exc_d;
    logic        timeout_q, timeout_d;

    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expired;
    logic        req_ready;
    logic        unit_done;

    assign req_ready = (state_q == ST_IDLE);
    // Only the unit that was launched can end WAIT; the other unit's done is ignored.
    assign unit_done = (op_q == OP_DIV) ? bus.div_done : bus.mult_done;

    muldiv_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        stg_hi_d     = stg_hi_q;
        stg_lo_d     = stg_lo_q;
        stg_zero_d   = stg_zero_q;
        mf_data_d    = mf_data_q;
        mf_valid_d   = 1'b0;
        mult_start_d = 1'b0;
        div_start_d  = 1'b0;
        dz_exc_d     = 1'b0;
        timeout_d    = timeout_q;
        wd_clear     = 1'b0;
        wd_enable    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (is_unit_op(bus.req_op)) begin
                        op_d         = bus.req_op;
                        mult_start_d = (bus.req_op == OP_MULT);
                        div_start_d  = (bus.req_op == OP_DIV);
                        state_d      = ST_ISSUE;
                    end else begin
                        mf_valid_d = 1'b1;
                        mf_data_d  = (bus.req_op == OP_MFHI) ? hi_q : lo_q;
                    end
                end
            end

            // Start pulse is on the wire this cycle; the unit drops its stale done at the next edge.
            ST_ISSUE: begin
                wd_clear = 1'b1;
                state_d  = ST_WAIT;
            end

            ST_WAIT: begin
                if (unit_done) begin
                    if (op_q == OP_DIV) begin
                        stg_hi_d   = bus.div_hi;
                        stg_lo_d   = bus.div_lo;
                        stg_zero_d = bus.div_zero;
                    end else begin
                        stg_hi_d   = bus.mult_hi;
                        stg_lo_d   = bus.mult_lo;
                        stg_zero_d = 1'b0;
                    end
                    state_d = ST_WB;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_enable = 1'b1;
                end
            end

            ST_WB: begin
                if ((op_q == OP_DIV) && stg_zero_q) begin
                    dz_exc_d = 1'b1;
                end else begin
                    hi_d = stg_hi_q;
                    lo_d = stg_lo_q;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_MULT;
            hi_q         <= '0;
            lo_q         <= '0;
            stg_hi_q     <= '0;
            stg_lo_q     <= '0;
            stg_zero_q   <= 1'b0;
            mf_data_q    <= '0;
            mf_valid_q   <= 1'b0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            dz_exc_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            stg_hi_q     <= stg_hi_d;
            stg_lo_q     <= stg_lo_d;
            stg_zero_q   <= stg_zero_d;
            mf_data_q    <= mf_data_d;
            mf_valid_q   <= mf_valid_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            dz_exc_q     <= dz_exc_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.stall        = bus.req_valid & ~req_ready;
    assign bus.mult_start   = mult_start_q;
    assign bus.div_start    = div_start_q;
    assign bus.hi_out       = hi_q;
    assign bus.lo_out       = lo_q;
    assign bus.mf_data      = mf_data_q;
    assign bus.mf_valid     = mf_valid_q;
    assign bus.div_zero_exc = dz_exc_q;
    assign bus.timeout_err  = timeout_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: a cycle model of the multiplier/divider answers start pulses,
// scenario tasks drive the control-unit side and check HI/LO, MF reads and error flags.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int LAT = 32;

    logic   clock;
    logic   reset;
    state_t dbg_state;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_hi_q[$];
    logic [31:0] exp_lo_q[$];
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    // ---------------- unit model ----------------
    logic [31:0] m_hi = '0, m_lo = '0, d_hi = '0, d_lo = '0;
    logic        d_zero = 1'b0;
    bit          div_never = 1'b0;
    int          mult_pulses = 0;
    int          div_pulses = 0;

    // Each unit clears done on the edge that samples start and raises it LAT cycles after start.
    initial begin : unit_model
        int m_cnt, d_cnt;
        bit m_act, d_act;
        m_cnt = 0; d_cnt = 0; m_act = 0; d_act = 0;
        bus.mult_done = 1'b0; bus.mult_hi = '0; bus.mult_lo = '0;
        bus.div_done = 1'b0; bus.div_zero = 1'b0; bus.div_hi = '0; bus.div_lo = '0;
        forever begin
            @(negedge clock);
            if (m_act) begin
                m_cnt++;
                if (m_cnt == 1) bus.mult_done = 1'b0;
                if (m_cnt == LAT) begin
                    bus.mult_done = 1'b1; bus.mult_hi = m_hi; bus.mult_lo = m_lo; m_act = 0;
                end
            end
            if (d_act) begin
                d_cnt++;
                if (d_cnt == 1) begin bus.div_done = 1'b0; bus.div_zero = 1'b0; end
                if (d_cnt == LAT && !div_never) begin
                    bus.div_done = 1'b1; bus.div_zero = d_zero; bus.div_hi = d_hi; bus.div_lo = d_lo; d_act = 0;
                end
            end
            if (bus.mult_start === 1'b1) begin mult_pulses++; m_act = 1; m_cnt = 0; end
            if (bus.div_start === 1'b1) begin div_pulses++; d_act = 1; d_cnt = 0; end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_op(input op_t op, input int max_wait, output bit ok);
        int w;
        w = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        while (bus.req_ready !== 1'b1 && w < max_wait) begin
            @(negedge clock);
            w++;
        end
        ok = (bus.req_ready === 1'b1);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic launch(input op_t op, input logic [31:0] hi, input logic [31:0] lo, output bit ok);
        if (op == OP_DIV) begin d_hi = hi; d_lo = lo; end
        else begin m_hi = hi; m_lo = lo; end
        send_op(op, 4, ok);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [101:0] outs;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op = OP_MULT;
        tick(3);
        reset = 1'b0;
        tick(1);
        outs = {bus.hi_out, bus.lo_out, bus.mf_data, bus.mf_valid, bus.mult_start,
                bus.div_start, bus.div_zero_exc, bus.timeout_err, bus.stall};
        n_cmp++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", outs); end
        n_cmp++;
        if (dbg_state !== ST_IDLE || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_state: got state %0d ready %b required 0/1", dbg_state, bus.req_ready);
        end
    endtask

    task automatic test_mult();
        bit ok; int p0, q0; logic [31:0] eh, el;
        exp_hi_q.push_back(32'hFFFF_FFFF);
        exp_lo_q.push_back(32'hFFFF_FFEB);
        p0 = mult_pulses; q0 = div_pulses;
        launch(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, ok);
        n_cmp++;
        if (!ok || bus.mult_start !== 1'b1) begin
            n_fail++; $display("FAIL mult_launch: accepted %b start %b required 1/1", ok, bus.mult_start);
        end
        tick(LAT + 1);
        n_cmp++;
        if (bus.hi_out !== cur_hi || bus.lo_out !== cur_lo) begin
            n_fail++; $display("FAIL mult_early_write: got %h/%h required %h/%h", bus.hi_out, bus.lo_out, cur_hi, cur_lo);
        end
        tick(1);
        eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
        n_cmp++;
        if (bus.hi_out !== eh || bus.lo_out !== el) begin
            n_fail++; $display("FAIL mult_result: got %h/%h required %h/%h", bus.hi_out, bus.lo_out, eh, el);
        end
        cur_hi = eh; cur_lo = el;
        n_cmp++;
        if (mult_pulses - p0 != 1 || div_pulses != q0) begin
            n_fail++; $display("FAIL mult_start_pulses: got mult %0d div %0d required 1/0", mult_pulses - p0, div_pulses - q0);
        end
    endtask

    task automatic test_div();
        bit ok; logic [31:0] eh, el, em;
        exp_hi_q.push_back(32'd2);
        exp_lo_q.push_back(32'd14);
        launch(OP_DIV, 32'd2, 32'd14, ok);
        n_cmp++;
        if (!ok || bus.div_start !== 1'b1 || bus.mult_start !== 1'b0) begin
            n_fail++; $display("FAIL div_launch: accepted %b div_start %b mult_start %b required 1/1/0", ok, bus.div_start, bus.mult_start);
        end
        tick(LAT + 2);
        eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
        n_cmp++;
        if (bus.hi_out !== eh || bus.lo_out !== el) begin
            n_fail++; $display("FAIL div_result: got %h/%h required %h/%h", bus.hi_out, bus.lo_out, eh, el);
        end
        cur_hi = eh; cur_lo = el;
        exp_q.push_back(cur_lo);
        send_op(OP_MFLO, 4, ok);
        em = exp_q.pop_front();
        n_cmp++;
        if (bus.mf_valid !== 1'b1 || bus.mf_data !== em) begin
            n_fail++; $display("FAIL mflo_read: got valid %b data %h required 1/%h", bus.mf_valid, bus.mf_data, em);
        end
        tick(1);
        n_cmp++;
        if (bus.mf_valid !== 1'b0) begin n_fail++; $display("FAIL mflo_pulse: got %b required 0", bus.mf_valid); end
    endtask

    task automatic test_div_zero();
        bit ok;
        d_zero = 1'b1;
        launch(OP_DIV, 32'hDEAD_BEEF, 32'h1234_5678, ok);
        tick(LAT + 1);
        n_cmp++;
        if (bus.div_zero_exc !== 1'b0) begin n_fail++; $display("FAIL dz_early: got %b required 0", bus.div_zero_exc); end
        tick(1);
        n_cmp++;
        if (bus.div_zero_exc !== 1'b1 || bus.hi_out !== cur_hi || bus.lo_out !== cur_lo) begin
            n_fail++; $display("FAIL dz_exc: got exc %b hi/lo %h/%h required 1 %h/%h", bus.div_zero_exc, bus.hi_out, bus.lo_out, cur_hi, cur_lo);
        end
        tick(1);
        n_cmp++;
        if (bus.div_zero_exc !== 1'b0) begin n_fail++; $display("FAIL dz_pulse: got %b required 0", bus.div_zero_exc); end
        d_zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] em;
        bus.req_valid = 1'b1; bus.req_op = OP_MFHI;
        exp_q.push_back(cur_hi);
        tick(1);
        em = exp_q.pop_front();
        n_cmp++;
        if (bus.mf_valid !== 1'b1 || bus.mf_data !== em || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_mfhi: got valid %b data %h ready %b required 1/%h/1", bus.mf_valid, bus.mf_data, bus.req_ready, em);
        end
        bus.req_op = OP_MFLO;
        exp_q.push_back(cur_lo);
        tick(1);
        bus.req_valid = 1'b0;
        em = exp_q.pop_front();
        n_cmp++;
        if (bus.mf_valid !== 1'b1 || bus.mf_data !== em) begin
            n_fail++; $display("FAIL b2b_mflo: got valid %b data %h required 1/%h", bus.mf_valid, bus.mf_data, em);
        end
        tick(1);
        n_cmp++;
        if (bus.mf_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b required 0", bus.mf_valid); end
    endtask

    task automatic test_mf_stall();
        bit ok, bad; int cyc; logic [31:0] em;
        launch(OP_MULT, 32'h0000_0015, 32'hA5A5_0000, ok);
        exp_q.push_back(32'h0000_0015);
        bus.req_valid = 1'b1; bus.req_op = OP_MFHI;
        bad = 0; cyc = 0;
        while (bus.req_ready !== 1'b1 && cyc < 100) begin
            if (bus.stall !== 1'b1) bad = 1;
            tick(1);
            cyc++;
        end
        n_cmp++;
        if (bad || cyc != LAT + 2) begin
            n_fail++; $display("FAIL mf_stall: got %0d stall cycles (gap %b) required %0d", cyc, bad, LAT + 2);
        end
        tick(1);
        bus.req_valid = 1'b0;
        em = exp_q.pop_front();
        n_cmp++;
        if (bus.mf_valid !== 1'b1 || bus.mf_data !== em) begin
            n_fail++; $display("FAIL mf_after_wb: got valid %b data %h required 1/%h", bus.mf_valid, bus.mf_data, em);
        end
        cur_hi = 32'h0000_0015; cur_lo = 32'hA5A5_0000;
    endtask

    task automatic test_timeout();
        bit ok; int k; logic [31:0] eh, el;
        div_never = 1'b1;
        launch(OP_DIV, 32'h7777_7777, 32'h8888_8888, ok);
        k = 0;
        while (bus.timeout_err !== 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        // 40 counted WAIT cycles; the abort lands within two cycles after that.
        n_cmp++;
        if (k < 41 || k > 42) begin
            n_fail++; $display("FAIL timeout_latency: got %0d cycles after start required 41..42", k);
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE || bus.hi_out !== cur_hi || bus.lo_out !== cur_lo) begin
            n_fail++; $display("FAIL timeout_state: got state %0d hi/lo %h/%h required 0 %h/%h", dbg_state, bus.hi_out, bus.lo_out, cur_hi, cur_lo);
        end
        div_never = 1'b0;
        exp_hi_q.push_back(32'h0BAD_F00D);
        exp_lo_q.push_back(32'h0000_0042);
        launch(OP_MULT, 32'h0BAD_F00D, 32'h0000_0042, ok);
        tick(LAT + 2);
        eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
        n_cmp++;
        if (bus.hi_out !== eh || bus.lo_out !== el || bus.timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL after_timeout: got %h/%h err %b required %h/%h 1", bus.hi_out, bus.lo_out, bus.timeout_err, eh, el);
        end
        cur_hi = eh; cur_lo = el;
    endtask

    task automatic test_reset_mid();
        bit ok; logic [101:0] outs; logic [31:0] eh, el;
        launch(OP_MULT, 32'h1111_1111, 32'h2222_2222, ok);
        tick(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        outs = {bus.hi_out, bus.lo_out, bus.mf_data, bus.mf_valid, bus.mult_start,
                bus.div_start, bus.div_zero_exc, bus.timeout_err, bus.stall};
        n_cmp++;
        if (outs !== '0 || dbg_state !== ST_IDLE) begin
            n_fail++; $display("FAIL midop_reset: got %h state %0d required 0 state 0", outs, dbg_state);
        end
        cur_hi = '0; cur_lo = '0;
        tick(30);
        n_cmp++;
        if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0 || dbg_state !== ST_IDLE) begin
            n_fail++; $display("FAIL stale_done: got %h/%h state %0d required 0/0 state 0", bus.hi_out, bus.lo_out, dbg_state);
        end
        exp_hi_q.push_back(32'h3333_3333);
        exp_lo_q.push_back(32'h4444_4444);
        launch(OP_MULT, 32'h3333_3333, 32'h4444_4444, ok);
        tick(LAT + 1);
        n_cmp++;
        if (bus.hi_out !== cur_hi || bus.lo_out !== cur_lo) begin
            n_fail++; $display("FAIL stale_done_early: got %h/%h required %h/%h", bus.hi_out, bus.lo_out, cur_hi, cur_lo);
        end
        tick(1);
        eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
        n_cmp++;
        if (bus.hi_out !== eh || bus.lo_out !== el) begin
            n_fail++; $display("FAIL post_reset_mult: got %h/%h required %h/%h", bus.hi_out, bus.lo_out, eh, el);
        end
        cur_hi = eh; cur_lo = el;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_mf_stall();
        test_timeout();
        test_reset_mid();
        tick(2);
        n_cmp++;
        if (exp_q.size() != 0 || exp_hi_q.size() != 0 || exp_lo_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d/%0d/%0d left required 0", exp_q.size(), exp_hi_q.size(), exp_lo_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
